// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_driver - multiplexed common-anode 7-seg driver
// Revision : 1.0 - double-buffered digit store, tear-free commit, blanking
// ============================================================================
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic                  commit,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  commit_pending,
    output logic [3:0]            slot
);

    localparam int                 c_CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [c_CNT_W-1:0] c_TERM      = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK     = c_CNT_W'(BLANK_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [3:0]         c_LAST_SLOT = 4'(NUM_DIGITS - 1);

    typedef struct packed {
        logic       dp;
        logic [3:0] nib;
    } entry_t;

    logic [c_CNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic [3:0]            slot_q, slot_d;
    logic                  pend_q, pend_d;
    entry_t                shadow_q [NUM_DIGITS];
    entry_t                shadow_d [NUM_DIGITS];
    entry_t                active_q [NUM_DIGITS];
    entry_t                active_d [NUM_DIGITS];
    logic [6:0]            seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;

    logic                  w_term;
    logic                  w_wrap;
    logic                  w_blank;
    logic                  w_cur_en;
    logic                  w_lit;
    entry_t                w_cur;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

    assign w_term  = (div_cnt_q == c_TERM);
    assign w_wrap  = w_term && (slot_q == c_LAST_SLOT);
    assign w_blank = (div_cnt_q < c_BLANK);

    always_comb begin
        div_cnt_d = div_cnt_q + c_CNT_ONE;
        slot_d    = slot_q;
        if (w_term) begin
            div_cnt_d = '0;
            slot_d    = (slot_q == c_LAST_SLOT) ? 4'd0 : slot_q + 4'd1;
        end
    end

    // Copy reads the pre-edge shadow, so a write on the wrap edge stays shadow-only.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        if (pend_q && w_wrap) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end else if (!pend_q && commit) begin
            pend_d = 1'b1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_en && (wr_addr == 4'(i))) begin
                shadow_d[i] = {wr_dp, wr_data};
            end
        end
    end

    always_comb begin
        w_cur    = '0;
        w_cur_en = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == 4'(i)) begin
                w_cur    = active_q[i];
                w_cur_en = digit_en[i];
            end
        end
    end

    assign w_lit = !w_blank && w_cur_en;

    always_comb begin
        seg_n_d = f_decode(w_cur.nib);
        dp_n_d  = ~w_cur.dp;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_n_d[i] = ~(w_lit && (slot_q == 4'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            slot_q    <= '0;
            pend_q    <= 1'b0;
            seg_n_q   <= 7'h7F;
            dp_n_q    <= 1'b1;
            an_n_q    <= '1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            div_cnt_q <= div_cnt_d;
            slot_q    <= slot_d;
            pend_q    <= pend_d;
            seg_n_q   <= seg_n_d;
            dp_n_q    <= dp_n_d;
            an_n_q    <= an_n_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign seg_n          = seg_n_q;
    assign dp_n           = dp_n_q;
    assign an_n           = an_n_q;
    assign commit_pending = pend_q;
    assign slot           = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_driver - scoreboard bench for the scan driver
// Revision : 1.0 - cycle model feeding an expected-output queue plus spot checks
// ============================================================================
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [3:0]    wr_data;
    logic          wr_dp;
    logic          commit;
    logic [ND-1:0] digit_en;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [ND-1:0] an_n;
    logic          commit_pending;
    logic [3:0]    slot;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] slot;
        logic       pend;
    } exp_t;

    exp_t       sb_q [$];
    int         m_cnt;
    int         m_slot;
    logic       m_pend;
    logic [4:0] m_sh [ND];
    logic [4:0] m_ac [ND];

    seven_seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_dp         (wr_dp),
        .commit        (commit),
        .digit_en      (digit_en),
        .seg_n         (seg_n),
        .dp_n          (dp_n),
        .an_n          (an_n),
        .commit_pending(commit_pending),
        .slot          (slot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h01;  4'h1: return 7'h4F;  4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;  4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;  4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;  4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_slot = 0;
        m_pend = 1'b0;
        for (int i = 0; i < ND; i++) begin
            m_sh[i] = '0;
            m_ac[i] = '0;
        end
        sb_q.delete();
    endtask

    task automatic model_step();
        exp_t       e;
        logic [3:0] hot;
        logic [4:0] cur;
        int         a;
        cur   = m_ac[m_slot];
        hot   = 4'b0001 << m_slot;
        e.an  = (m_cnt < BC || !digit_en[m_slot]) ? 4'hF : ~hot;
        e.seg = dec(cur[3:0]);
        e.dp  = ~cur[4];
        if (m_pend && m_cnt == RD - 1 && m_slot == ND - 1) begin
            for (int i = 0; i < ND; i++) m_ac[i] = m_sh[i];
            m_pend = 1'b0;
        end else if (!m_pend && commit) begin
            m_pend = 1'b1;
        end
        a = int'(wr_addr);
        if (wr_en && a < ND) m_sh[a] = {wr_dp, wr_data};
        if (m_cnt == RD - 1) begin
            m_cnt  = 0;
            m_slot = (m_slot == ND - 1) ? 0 : m_slot + 1;
        end else begin
            m_cnt++;
        end
        e.slot = 4'(m_slot);
        e.pend = m_pend;
        sb_q.push_back(e);
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin : scoreboard
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_an_n", 32'(an_n), 32'(e.an));
                chk("sb_seg_n", 32'(seg_n), 32'(e.seg));
                chk("sb_dp_n", 32'(dp_n), 32'(e.dp));
                chk("sb_slot", 32'(slot), 32'(e.slot));
                chk("sb_pending", 32'(commit_pending), 32'(e.pend));
            end
        end
    end

    // Returns at the negedge where the DUT sits at (s, c); inputs driven now hit that edge.
    task automatic wait_pos(input int s, input int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_slot == s && m_cnt == c) && n < 200);
        if (!(m_slot == s && m_cnt == c)) chk("wait_pos_timeout", 32'(n), 32'(0));
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d, input logic p);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic pass_wrap();
        wait_pos(ND - 1, RD - 1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : stimulus
        int         lit [ND];
        logic [3:0] cold;
        logic [6:0] exp_seg [ND];
        logic       exp_dp  [ND];
        exp_seg = '{7'h4F, 7'h08, 7'h0F, 7'h38};
        exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b0;
        commit = 1'b0; digit_en = 4'hF;
        for (int d = 0; d < ND; d++) lit[d] = 0;

        // Reset state, then one full frame of scanning from cleared store
        repeat (3) @(negedge clk);
        chk("rst_seg_n", 32'(seg_n), 32'h7F);
        chk("rst_dp_n", 32'(dp_n), 32'h1);
        chk("rst_an_n", 32'(an_n), 32'hF);
        chk("rst_pending", 32'(commit_pending), 32'h0);
        chk("rst_slot", 32'(slot), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= ND * RD; k++) begin
            @(negedge clk);
            chk("s1_slot_seq", 32'(slot), 32'((k / RD) % ND));
            chk("s1_seg_zero", 32'(seg_n), 32'h01);
            for (int d = 0; d < ND; d++) begin
                cold = ~(4'b0001 << d);
                if (an_n == cold) lit[d]++;
            end
        end
        for (int d = 0; d < ND; d++) chk("s1_lit_cycles", 32'(lit[d]), 32'd6);

        // Write 1,A,7,F with dp on digit 2, commit, see the frame switch at wrap
        do_write(4'd0, 4'h1, 1'b0);
        do_write(4'd1, 4'hA, 1'b0);
        do_write(4'd2, 4'h7, 1'b1);
        do_write(4'd3, 4'hF, 1'b0);
        pulse_commit();
        wait_pos(1, 4);
        chk("s2_before_wrap_seg", 32'(seg_n), 32'h01);
        chk("s2_pending_set", 32'(commit_pending), 32'h1);
        wait_pos(ND - 1, RD - 1);
        chk("s2_pending_pre_wrap", 32'(commit_pending), 32'h1);
        @(negedge clk);
        chk("s2_pending_fall", 32'(commit_pending), 32'h0);
        for (int s = 0; s < ND; s++) begin
            wait_pos(s, 4);
            chk("s2_seg_after_commit", 32'(seg_n), 32'(exp_seg[s]));
            chk("s2_dp_after_commit", 32'(dp_n), 32'(exp_dp[s]));
        end

        // Per-digit enable and blanking window
        digit_en = 4'b1010;
        wait_pos(0, 4); chk("s3_slot0_dark", 32'(an_n), 32'hF);
        wait_pos(1, 1); chk("s3_slot1_blank0", 32'(an_n), 32'hF);
        wait_pos(1, 2); chk("s3_slot1_blank1", 32'(an_n), 32'hF);
        wait_pos(1, 3); chk("s3_slot1_lit", 32'(an_n), 32'b1101);
        wait_pos(2, 4); chk("s3_slot2_dark", 32'(an_n), 32'hF);
        wait_pos(3, 4); chk("s3_slot3_lit", 32'(an_n), 32'b0111);
        digit_en = 4'hF;

        // Out-of-range write address is dropped
        do_write(4'd5, 4'h8, 1'b1);
        pulse_commit();
        pass_wrap();
        chk("s4_badaddr_pending", 32'(commit_pending), 32'h0);
        wait_pos(1, 4);
        chk("s4_badaddr_seg", 32'(seg_n), 32'h08);
        chk("s4_badaddr_dp", 32'(dp_n), 32'h1);

        // Second commit while pending yields exactly one copy
        pulse_commit();
        do_write(4'd0, 4'h2, 1'b0);
        pulse_commit();
        pass_wrap();
        chk("s4_one_copy_pending", 32'(commit_pending), 32'h0);
        wait_pos(0, 4);
        chk("s4_copied_seg", 32'(seg_n), 32'h12);
        do_write(4'd0, 4'h3, 1'b0);
        pass_wrap();
        chk("s4_no_second_pending", 32'(commit_pending), 32'h0);
        wait_pos(0, 4);
        chk("s4_no_second_copy", 32'(seg_n), 32'h12);

        // Write landing on the copy edge stays in the shadow store
        pulse_commit();
        wait_pos(ND - 1, RD - 1);
        do_write(4'd1, 4'h5, 1'b0);
        chk("s4_wrapwr_pending", 32'(commit_pending), 32'h0);
        wait_pos(0, 4);
        chk("s4_wrapwr_d0", 32'(seg_n), 32'h06);
        wait_pos(1, 4);
        chk("s4_wrapwr_hidden", 32'(seg_n), 32'h08);
        pulse_commit();
        pass_wrap();
        wait_pos(1, 4);
        chk("s4_wrapwr_later", 32'(seg_n), 32'h24);

        // Asynchronous reset mid-frame with a commit pending
        pulse_commit();
        wait_pos(2, 4);
        chk("s5_pending_before", 32'(commit_pending), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_async_seg_n", 32'(seg_n), 32'h7F);
        chk("s5_async_dp_n", 32'(dp_n), 32'h1);
        chk("s5_async_an_n", 32'(an_n), 32'hF);
        chk("s5_async_pending", 32'(commit_pending), 32'h0);
        chk("s5_async_slot", 32'(slot), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_pos(1, 4);
        chk("s5_active_cleared", 32'(seg_n), 32'h01);
        wait_pos(2, 4);
        chk("s5_dp_cleared", 32'(dp_n), 32'h1);
        pass_wrap();
        chk("s5_pending_lost", 32'(commit_pending), 32'h0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
